// File: rtl/mc_datapath_hs.sv
`timescale 1ns/1ps
// Multicycle RISC-V datapath with a req/ready memory handshake.
// While a memory access is outstanding, Stall freezes every architectural
// register so the controller can sit on wait-stated memories.
//
// Handshake states:
//   state  | meaning
//   S_IDLE | no access in flight; a new access is issued combinationally
//   S_WAIT | access issued, waiting for mem_ready; request fields held in latches
module mc_datapath_hs #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          REG_ADDR_WIDTH = 5,
  parameter logic [31:0] RESET_PC       = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PCWrite,
  input  logic                  RegWrite,
  input  logic                  IRWrite,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  AdrSrc,
  input  logic [1:0]            ResultSrc,
  input  logic [1:0]            ALUSrcA,
  input  logic [1:0]            ALUSrcB,
  input  logic [3:0]            ALUControl,
  input  logic [2:0]            ImmSrc,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  Stall,
  output logic                  Zero,
  output logic                  Lt,
  output logic                  Ltu,
  output logic [6:0]            Op,
  output logic [2:0]            Funct3,
  output logic [6:0]            Funct7
);

  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam int NREG = 2 ** REG_ADDR_WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } hs_state_t;

  hs_state_t state, state_next;

  logic [DATA_WIDTH-1:0] pc, old_pc, a_reg, b_reg, alu_out, data_reg;
  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] rf [NREG];

  logic [REG_ADDR_WIDTH-1:0] ra1, ra2, wa;
  logic [DATA_WIDTH-1:0]     rd1, rd2;

  logic [DATA_WIDTH-1:0] src_a, src_b, alu_result, result, adr, imm_ext;
  logic [31:0]           imm32;
  logic [SHW-1:0]        shamt;
  logic                  lt_s, lt_u;

  logic                  access;
  logic                  req_int, stall_int, capture;
  logic [DATA_WIDTH-1:0] addr_int, wdata_int;
  logic                  we_int;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic                  we_q;
  logic                  stall;

  assign access = MemRead | MemWrite;

  // Handshake state register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Handshake next state and memory-side outputs.
  always_comb begin
    state_next = state;
    req_int    = 1'b0;
    stall_int  = 1'b0;
    capture    = 1'b0;
    addr_int   = adr;
    we_int     = MemWrite;
    wdata_int  = b_reg;
    case (state)
      S_IDLE: begin
        if (access) begin
          req_int = 1'b1;
          if (!mem_ready) begin
            stall_int  = 1'b1;
            capture    = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req_int   = 1'b1;
        addr_int  = addr_q;
        we_int    = we_q;
        wdata_int = wdata_q;
        if (mem_ready) state_next = S_IDLE;
        else           stall_int  = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Reset forces the request and stall low even while controls are still asserted.
  assign mem_req   = req_int & ~reset;
  assign stall     = stall_int & ~reset;
  assign Stall     = stall;
  assign mem_addr  = addr_int;
  assign mem_we    = we_int;
  assign mem_wdata = wdata_int;

  // Hold the request fields stable for the whole wait period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (capture) begin
      addr_q  <= adr;
      we_q    <= MemWrite;
      wdata_q <= b_reg;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 pc <= DATA_WIDTH'(RESET_PC);
    else if (PCWrite && !stall) pc <= result;
  end

  // Instruction register and the PC it was fetched from.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir     <= '0;
      old_pc <= '0;
    end else if (IRWrite && !stall) begin
      ir     <= mem_rdata[31:0];
      old_pc <= pc;
    end
  end

  // Always-enabled pipeline registers, frozen only by a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      alu_out  <= '0;
      data_reg <= '0;
    end else if (!stall) begin
      a_reg    <= rd1;
      b_reg    <= rd2;
      alu_out  <= alu_result;
      data_reg <= mem_rdata;
    end
  end

  assign ra1 = ir[15 +: REG_ADDR_WIDTH];
  assign ra2 = ir[20 +: REG_ADDR_WIDTH];
  assign wa  = ir[7 +: REG_ADDR_WIDTH];

  // Entry 0 is never written, so reading it directly always yields zero.
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  // Register file write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (RegWrite && !stall && (wa != '0)) begin
      rf[wa] <= result;
    end
  end

  // Immediate generator: build the 32-bit field, then sign-extend.
  always_comb begin
    imm32 = 32'd0;
    case (ImmSrc)
      3'd0: imm32 = {{20{ir[31]}}, ir[31:20]};
      3'd1: imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      3'd2: imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      3'd3: imm32 = {ir[31:12], 12'd0};
      3'd4: imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm_ext = DATA_WIDTH'($signed(imm32));

  // ALU operand selection.
  always_comb begin
    src_a = '0;
    case (ALUSrcA)
      2'd0: src_a = pc;
      2'd1: src_a = old_pc;
      2'd2: src_a = a_reg;
      default: src_a = '0;
    endcase
    src_b = '0;
    case (ALUSrcB)
      2'd0: src_b = b_reg;
      2'd1: src_b = imm_ext;
      2'd2: src_b = DATA_WIDTH'(4);
      default: src_b = '0;
    endcase
  end

  assign shamt = src_b[SHW-1:0];
  assign lt_s  = $signed(src_a) < $signed(src_b);
  assign lt_u  = src_a < src_b;

  // ALU operation.
  always_comb begin
    alu_result = '0;
    case (ALUControl)
      4'd0: alu_result = src_a + src_b;
      4'd1: alu_result = src_a - src_b;
      4'd2: alu_result = src_a & src_b;
      4'd3: alu_result = src_a | src_b;
      4'd4: alu_result = src_a ^ src_b;
      4'd5: alu_result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      4'd6: alu_result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      4'd7: alu_result = src_a << shamt;
      4'd8: alu_result = src_a >> shamt;
      4'd9: alu_result = $unsigned($signed(src_a) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  assign Zero = (alu_result == '0);
  assign Lt   = lt_s;
  assign Ltu  = lt_u;

  // Result and memory address selection.
  always_comb begin
    result = '0;
    case (ResultSrc)
      2'd0: result = alu_out;
      2'd1: result = data_reg;
      2'd2: result = alu_result;
      default: result = imm_ext;
    endcase
    adr = AdrSrc ? result : pc;
  end

  assign Op     = ir[6:0];
  assign Funct3 = ir[14:12];
  assign Funct7 = ir[31:25];

endmodule
